// File: rtl/register_file_pkg.sv
// Shared configuration for the dual-port register file: word and address
// widths, the derived register count and the matching typedefs.
// The optional REGFILE_BYPASS_EN macro is consumed by register_file.sv.
package register_file_pkg;

    localparam int WORD_SIZE    = 32;
    localparam int REGADDR_SIZE = 5;
    localparam int NUM_REGS     = 1 << REGADDR_SIZE;

    typedef logic [WORD_SIZE-1:0]    word_t;
    typedef logic [REGADDR_SIZE-1:0] regaddr_t;

endpackage

// File: rtl/regfile_read_port.sv
// One registered read port: dout loads on rd, otherwise holds.
// A forwarding hit substitutes the in-flight write data for the stored word.
// The hit is tied low when REGFILE_BYPASS_EN is undefined.
module regfile_read_port
    import register_file_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  rd,
    input  word_t rd_data,
    input  logic  fwd_hit,
    input  word_t fwd_data,
    output word_t dout
);

    word_t next_data;

    // Pick forwarded write data over the stored contents on a hit.
    always_comb begin
        next_data = rd_data;
        if (fwd_hit) begin
            next_data = fwd_data;
        end
    end

    // Registered read data; holds its value while rd is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dout <= '0;
        end else if (rd) begin
            dout <= next_data;
        end
    end

endmodule

// File: rtl/register_file.sv
// Dual-port general-purpose register file with registered reads.
// Port A wins a same-address write collision. Reads default to old data
// (read-before-write); defining REGFILE_BYPASS_EN enables write-through
// forwarding, with port A's data taking priority.
module register_file
    import register_file_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     wen_a,
    input  logic     rd_a,
    input  regaddr_t addr_a,
    input  word_t    din_a,
    output word_t    dout_a,
    input  logic     wen_b,
    input  logic     rd_b,
    input  regaddr_t addr_b,
    input  word_t    din_b,
    output word_t    dout_b
);

    word_t mem [NUM_REGS];
    logic  b_dropped;
    logic  fwd_hit_a;
    logic  fwd_hit_b;
    word_t fwd_data_a;
    word_t fwd_data_b;

    // Port B's write is suppressed when port A writes the same register.
    always_comb begin
        b_dropped = wen_a && wen_b && (addr_a == addr_b);
    end

    // Storage array: asynchronous clear, then per-port synchronous writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem <= '{default: '0};
        end else begin
            if (wen_a) begin
                mem[addr_a] <= din_a;
            end
            if (wen_b && !b_dropped) begin
                mem[addr_b] <= din_b;
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    // Forwarding select for each reader; port A's write data has priority.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
        if (wen_a) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = din_a;
        end else if (wen_b && (addr_b == addr_a)) begin
            fwd_hit_a  = 1'b1;
            fwd_data_a = din_b;
        end
        if (wen_a && (addr_a == addr_b)) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = din_a;
        end else if (wen_b) begin
            fwd_hit_b  = 1'b1;
            fwd_data_b = din_b;
        end
    end
`else
    // No forwarding: readers always see the pre-write contents.
    always_comb begin
        fwd_hit_a  = 1'b0;
        fwd_data_a = '0;
        fwd_hit_b  = 1'b0;
        fwd_data_b = '0;
    end
`endif

    regfile_read_port u_port_a (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd_a),
        .rd_data  (mem[addr_a]),
        .fwd_hit  (fwd_hit_a),
        .fwd_data (fwd_data_a),
        .dout     (dout_a)
    );

    regfile_read_port u_port_b (
        .clk      (clk),
        .rst      (rst),
        .rd       (rd_b),
        .rd_data  (mem[addr_b]),
        .fwd_hit  (fwd_hit_b),
        .fwd_data (fwd_data_b),
        .dout     (dout_b)
    );

endmodule

// File: tb/tb_register_file.sv
// Directed self-checking bench for register_file.
// Expected same-cycle read/write results follow REGFILE_BYPASS_EN.
module tb_register_file;
    import register_file_pkg::*;

    logic     clk;
    logic     rst;
    logic     wen_a;
    logic     rd_a;
    regaddr_t addr_a;
    word_t    din_a;
    word_t    dout_a;
    logic     wen_b;
    logic     rd_b;
    regaddr_t addr_b;
    word_t    din_b;
    word_t    dout_b;

    int n_tests;
    int n_fail;

    register_file dut (
        .clk    (clk),
        .rst    (rst),
        .wen_a  (wen_a),
        .rd_a   (rd_a),
        .addr_a (addr_a),
        .din_a  (din_a),
        .dout_a (dout_a),
        .wen_b  (wen_b),
        .rd_b   (rd_b),
        .addr_b (addr_b),
        .din_b  (din_b),
        .dout_b (dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t got, input word_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen_a = 1'b0; rd_a = 1'b0; addr_a = '0; din_a = '0;
        wen_b = 1'b0; rd_b = 1'b0; addr_b = '0; din_b = '0;
    endtask

    function automatic word_t pat(input int i);
        return {16'hC0DE, 8'(i), 8'(~i)};
    endfunction

    word_t exp_same;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        idle();
        rst = 1'b0;
        #1;
        check("reset_dout_a", dout_a, '0);
        check("reset_dout_b", dout_b, '0);
        step();
        rst = 1'b1;
        step();

        // Basic write then read on port A, then hold with rd_a low.
        wen_a = 1'b1; addr_a = 5'd0; din_a = 32'hABCDEF00;
        step();
        idle(); rd_a = 1'b1; addr_a = 5'd0;
        step();
        check("basic_read", dout_a, 32'hABCDEF00);
        idle();
        step();
        check("basic_hold", dout_a, 32'hABCDEF00);

        // Independent writes on both ports, cross-read next cycle.
        wen_a = 1'b1; addr_a = 5'd3; din_a = 32'h11111111;
        wen_b = 1'b1; addr_b = 5'd7; din_b = 32'h22222222;
        step();
        idle(); rd_a = 1'b1; addr_a = 5'd7; rd_b = 1'b1; addr_b = 5'd3;
        step();
        check("dual_a_reads_7", dout_a, 32'h22222222);
        check("dual_b_reads_3", dout_b, 32'h11111111);

        // Write collision on reg 5: port A must win.
        idle();
        wen_a = 1'b1; addr_a = 5'd5; din_a = 32'hAAAA0000;
        wen_b = 1'b1; addr_b = 5'd5; din_b = 32'hBBBB0000;
        step();
        idle(); rd_a = 1'b1; addr_a = 5'd5; rd_b = 1'b1; addr_b = 5'd5;
        step();
        check("collision_a", dout_a, 32'hAAAA0000);
        check("collision_b", dout_b, 32'hAAAA0000);

        // Same-cycle read/write on reg 9 from both the writing and the other port.
        idle();
        wen_a = 1'b1; addr_a = 5'd9; din_a = 32'h12345678;
        step();
        idle();
        wen_a = 1'b1; rd_a = 1'b1; addr_a = 5'd9; din_a = 32'hDEADBEEF;
        rd_b = 1'b1; addr_b = 5'd9;
        step();
`ifdef REGFILE_BYPASS_EN
        exp_same = 32'hDEADBEEF;
`else
        exp_same = 32'h12345678;
`endif
        check("rw_same_cycle_b", dout_b, exp_same);
        check("rw_same_cycle_a", dout_a, exp_same);
        idle(); rd_b = 1'b1; addr_b = 5'd9;
        step();
        check("rw_next_cycle", dout_b, 32'hDEADBEEF);

        // Port B write with port A reading the same address.
        idle();
        wen_b = 1'b1; addr_b = 5'd12; din_b = 32'h0F0F0F0F;
        rd_a = 1'b1; addr_a = 5'd12;
        step();
`ifdef REGFILE_BYPASS_EN
        check("cross_b_to_a", dout_a, 32'h0F0F0F0F);
`else
        check("cross_b_to_a", dout_a, 32'h00000000);
`endif

        // Hold: rd_b low while writes land, including on the held address.
        for (int k = 0; k < 3; k++) begin
            idle();
            wen_a = 1'b1; addr_a = 5'd9;  din_a = 32'h5A5A0000 + 32'(k);
            wen_b = 1'b1; addr_b = 5'd10; din_b = 32'hA5A50000 + 32'(k);
            step();
            check("hold_dout_b", dout_b, 32'hDEADBEEF);
        end

        // Asynchronous reset mid-cycle after nonzero data has been read.
        idle();
        wen_a = 1'b1; addr_a = 5'd20; din_a = 32'h76543210;
        step();
        idle(); rd_a = 1'b1; addr_a = 5'd20; rd_b = 1'b1; addr_b = 5'd3;
        step();
        check("pre_reset_a", dout_a, 32'h76543210);
        check("pre_reset_b", dout_b, 32'h11111111);
        #3;
        rst = 1'b0;
        #1;
        check("async_reset_a", dout_a, '0);
        check("async_reset_b", dout_b, '0);
        step();
        rst = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) begin
            idle();
            rd_a = 1'b1; addr_a = regaddr_t'(i);
            rd_b = 1'b1; addr_b = regaddr_t'(NUM_REGS - 1 - i);
            step();
            check($sformatf("post_reset_a_r%0d", i), dout_a, '0);
            check($sformatf("post_reset_b_r%0d", NUM_REGS - 1 - i), dout_b, '0);
        end

        // Fill every register with a distinct pattern, then read back across ports.
        for (int i = 0; i < NUM_REGS; i += 2) begin
            idle();
            wen_a = 1'b1; addr_a = regaddr_t'(i);     din_a = pat(i);
            wen_b = 1'b1; addr_b = regaddr_t'(i + 1); din_b = pat(i + 1);
            step();
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            idle();
            rd_a = 1'b1; addr_a = regaddr_t'(NUM_REGS - 1 - i);
            rd_b = 1'b1; addr_b = regaddr_t'(i);
            step();
            check($sformatf("fill_a_r%0d", NUM_REGS - 1 - i), dout_a, pat(NUM_REGS - 1 - i));
            check($sformatf("fill_b_r%0d", i), dout_b, pat(i));
        end

        idle();
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
